running_line_ctrl: RTL and testbench

Scroll controller for the running-line display. Sits on the pixel clock beside the 640x480 display timing generator: it consumes the raster coordinates, owns the horizontal scroll offset and the run/pause/stop state, and produces per-pixel message-ROM and glyph coordinates for the downstream font/colour stage. Scroll updates and commands take effect only at frame boundaries, so a frame never tears.

---
 rtl/running_line_pkg.sv | 26 ++
 rtl/line_pixel_map.sv | 65 ++++++
 rtl/running_line_ctrl.sv | 123 ++++++++++++
 tb/tb_running_line_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/running_line_pkg.sv
// Shared types and default geometry for the running-line scroll controller.
package running_line_pkg;

  // Default display and font geometry.
  localparam int unsigned DEF_CORDW   = 10;
  localparam int unsigned DEF_H_RES   = 640;
  localparam int unsigned DEF_V_RES   = 480;
  localparam int unsigned DEF_LINE_Y  = 224;
  localparam int unsigned DEF_FONT_W  = 8;
  localparam int unsigned DEF_FONT_H  = 8;
  localparam int unsigned DEF_SCALE   = 4;
  localparam int unsigned DEF_MSG_LEN = 64;

  // Derived widths for the default geometry.
  localparam int unsigned OW  = $clog2(DEF_MSG_LEN * DEF_FONT_W);
  localparam int unsigned CAW = $clog2(DEF_MSG_LEN);
  localparam int unsigned GCW = $clog2(DEF_FONT_W);
  localparam int unsigned GRW = $clog2(DEF_FONT_H);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StPause = 2'd2
  } rl_state_e;

endpackage

// File: rtl/line_pixel_map.sv
// Registered raster-to-glyph mapping: turns sx/sy/de plus scroll offset into
// message ROM address and glyph coordinates, one cycle behind the raster.
module line_pixel_map
  import running_line_pkg::*;
#(
  parameter int unsigned CORDW   = DEF_CORDW,
  parameter int unsigned LINE_Y  = DEF_LINE_Y,
  parameter int unsigned FONT_W  = DEF_FONT_W,
  parameter int unsigned FONT_H  = DEF_FONT_H,
  parameter int unsigned SCALE   = DEF_SCALE,
  parameter int unsigned MSG_LEN = DEF_MSG_LEN,
  localparam int unsigned OffW   = $clog2(MSG_LEN * FONT_W),
  localparam int unsigned CaW    = $clog2(MSG_LEN),
  localparam int unsigned GcW    = $clog2(FONT_W),
  localparam int unsigned GrW    = $clog2(FONT_H)
) (
  input  logic             clk_pix,
  input  logic             rst_n,
  input  logic [CORDW-1:0] sx,
  input  logic [CORDW-1:0] sy,
  input  logic             de,
  input  logic             active,
  input  logic [OffW-1:0]  offset,
  output logic [CaW-1:0]   char_addr,
  output logic [GcW-1:0]   glyph_col,
  output logic [GrW-1:0]   glyph_row,
  output logic             line_en
);

  localparam int unsigned ScaleSh = $clog2(SCALE);
  localparam int unsigned FontSh  = $clog2(FONT_W);

  logic [OffW-1:0] text_x;
  logic            band;
  logic [CaW-1:0]  char_addr_d;
  logic [GcW-1:0]  glyph_col_d;
  logic [GrW-1:0]  glyph_row_d;
  logic            line_en_d;

  // Combinational map; the offset add wraps modulo the message width by truncation.
  always_comb begin
    text_x      = OffW'(sx >> ScaleSh) + offset;
    band        = (sy >= CORDW'(LINE_Y)) && (sy < CORDW'(LINE_Y + FONT_H * SCALE));
    char_addr_d = CaW'(text_x >> FontSh);
    glyph_col_d = GcW'(text_x);
    glyph_row_d = GrW'((sy - CORDW'(LINE_Y)) >> ScaleSh);
    line_en_d   = band && de && active;
  end

  // Output registers; downstream delays syncs by one cycle to match.
  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      char_addr <= '0;
      glyph_col <= '0;
      glyph_row <= '0;
      line_en   <= 1'b0;
    end else begin
      char_addr <= char_addr_d;
      glyph_col <= glyph_col_d;
      glyph_row <= glyph_row_d;
      line_en   <= line_en_d;
    end
  end

endmodule

// File: rtl/running_line_ctrl.sv
// Scroll controller: captures commands, runs the IDLE/RUN/PAUSE FSM and the
// offset accumulator, all updated only at the frame boundary.
module running_line_ctrl
  import running_line_pkg::*;
#(
  parameter int unsigned CORDW   = DEF_CORDW,
  parameter int unsigned H_RES   = DEF_H_RES,
  parameter int unsigned V_RES   = DEF_V_RES,
  parameter int unsigned LINE_Y  = DEF_LINE_Y,
  parameter int unsigned FONT_W  = DEF_FONT_W,
  parameter int unsigned FONT_H  = DEF_FONT_H,
  parameter int unsigned SCALE   = DEF_SCALE,
  parameter int unsigned MSG_LEN = DEF_MSG_LEN,
  localparam int unsigned OffW   = $clog2(MSG_LEN * FONT_W),
  localparam int unsigned CaW    = $clog2(MSG_LEN),
  localparam int unsigned GcW    = $clog2(FONT_W),
  localparam int unsigned GrW    = $clog2(FONT_H)
) (
  input  logic             clk_pix,
  input  logic             rst_n,
  input  logic [CORDW-1:0] sx,
  input  logic [CORDW-1:0] sy,
  input  logic             de,
  input  logic             cmd_start,
  input  logic             cmd_stop,
  input  logic             cmd_pause,
  input  logic             dir,
  input  logic [3:0]       speed,
  output logic [CaW-1:0]   char_addr,
  output logic [GcW-1:0]   glyph_col,
  output logic [GrW-1:0]   glyph_row,
  output logic             line_en,
  output rl_state_e        state,
  output logic [OffW-1:0]  offset
);

  rl_state_e       state_q, state_d;
  logic [OffW-1:0] offset_q, offset_d;
  logic            pend_start_q, pend_start_d;
  logic            pend_stop_q, pend_stop_d;
  logic            pend_pause_q, pend_pause_d;
  logic            frame_tick;
  logic            do_start, do_stop, do_pause;

  assign frame_tick = (sx == CORDW'(H_RES)) && (sy == CORDW'(V_RES));

  // Pulses on the tick cycle itself are folded in so they act at that tick.
  assign do_stop  = pend_stop_q  | cmd_stop;
  assign do_start = pend_start_q | cmd_start;
  assign do_pause = pend_pause_q | cmd_pause;

  // Next state: command capture, FSM and offset advance.
  always_comb begin
    state_d      = state_q;
    offset_d     = offset_q;
    pend_start_d = do_start;
    pend_stop_d  = do_stop;
    pend_pause_d = do_pause;
    if (frame_tick) begin
      pend_start_d = 1'b0;
      pend_stop_d  = 1'b0;
      pend_pause_d = 1'b0;
      if (do_stop) begin
        state_d  = StIdle;
        offset_d = '0;
      end else if (do_start) begin
        state_d  = StRun;
        offset_d = '0;
      end else if (do_pause) begin
        // Pause in IDLE falls through unchanged.
        if (state_q == StRun) begin
          state_d = StPause;
        end else if (state_q == StPause) begin
          state_d = StRun;
        end
      end else if (state_q == StRun) begin
        offset_d = dir ? (offset_q - OffW'(speed)) : (offset_q + OffW'(speed));
      end
    end
  end

  // State, offset and pending-command registers.
  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      offset_q     <= '0;
      pend_start_q <= 1'b0;
      pend_stop_q  <= 1'b0;
      pend_pause_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      offset_q     <= offset_d;
      pend_start_q <= pend_start_d;
      pend_stop_q  <= pend_stop_d;
      pend_pause_q <= pend_pause_d;
    end
  end

  assign state  = state_q;
  assign offset = offset_q;

  line_pixel_map #(
    .CORDW  (CORDW),
    .LINE_Y (LINE_Y),
    .FONT_W (FONT_W),
    .FONT_H (FONT_H),
    .SCALE  (SCALE),
    .MSG_LEN(MSG_LEN)
  ) u_map (
    .clk_pix  (clk_pix),
    .rst_n    (rst_n),
    .sx       (sx),
    .sy       (sy),
    .de       (de),
    .active   (state_q != StIdle),
    .offset   (offset_q),
    .char_addr(char_addr),
    .glyph_col(glyph_col),
    .glyph_row(glyph_row),
    .line_en  (line_en)
  );

endmodule

// File: tb/tb_running_line_ctrl.sv
// Directed bench for running_line_ctrl: frame ticks are forced by driving
// sx/sy to the tick coordinate for one cycle instead of sweeping the raster.
module tb_running_line_ctrl;
  import running_line_pkg::*;

  localparam int unsigned LY = 224;

  logic            clk_pix = 1'b0;
  logic            rst_n   = 1'b0;
  logic [9:0]      sx      = '0;
  logic [9:0]      sy      = '0;
  logic            de      = 1'b0;
  logic            cmd_start = 1'b0;
  logic            cmd_stop  = 1'b0;
  logic            cmd_pause = 1'b0;
  logic            dir     = 1'b0;
  logic [3:0]      speed   = '0;
  logic [5:0]      char_addr;
  logic [2:0]      glyph_col;
  logic [2:0]      glyph_row;
  logic            line_en;
  rl_state_e       state;
  logic [8:0]      offset;

  int n_vec = 0;
  int n_bad = 0;

  running_line_ctrl dut (
    .clk_pix  (clk_pix),
    .rst_n    (rst_n),
    .sx       (sx),
    .sy       (sy),
    .de       (de),
    .cmd_start(cmd_start),
    .cmd_stop (cmd_stop),
    .cmd_pause(cmd_pause),
    .dir      (dir),
    .speed    (speed),
    .char_addr(char_addr),
    .glyph_col(glyph_col),
    .glyph_row(glyph_row),
    .line_en  (line_en),
    .state    (state),
    .offset   (offset)
  );

  always #5 clk_pix = ~clk_pix;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One cycle at the frame-tick coordinate, then back to the origin.
  task automatic tick();
    sx = 10'd640;
    sy = 10'd480;
    @(posedge clk_pix);
    @(negedge clk_pix);
    sx = '0;
    sy = '0;
  endtask

  task automatic pulse_start();
    cmd_start = 1'b1;
    @(negedge clk_pix);
    cmd_start = 1'b0;
  endtask

  task automatic pulse_stop();
    cmd_stop = 1'b1;
    @(negedge clk_pix);
    cmd_stop = 1'b0;
  endtask

  task automatic pulse_pause();
    cmd_pause = 1'b1;
    @(negedge clk_pix);
    cmd_pause = 1'b0;
  endtask

  // Present one pixel and wait for its registered result.
  task automatic pix(input int x, input int y, input logic d);
    sx = 10'(x);
    sy = 10'(y);
    de = d;
    @(posedge clk_pix);
    @(negedge clk_pix);
  endtask

  initial begin
    // Reset state.
    repeat (3) @(negedge clk_pix);
    chk("rst_state", 32'(state), 0);
    chk("rst_offset", 32'(offset), 0);
    chk("rst_line_en", 32'(line_en), 0);
    rst_n = 1'b1;
    @(negedge clk_pix);

    // Start at sx=10, sy=0; applied at the next tick with offset 0.
    speed = 4'd2;
    dir   = 1'b0;
    sx    = 10'd10;
    pulse_start();
    sx = '0;
    chk("start_pending_state", 32'(state), 0);
    tick();
    chk("start_state", 32'(state), 1);
    chk("start_offset", 32'(offset), 0);
    tick();
    chk("adv_offset_2", 32'(offset), 2);
    tick();
    chk("adv_offset_4", 32'(offset), 4);
    tick();
    chk("adv_offset_6", 32'(offset), 6);

    // Pixel map with offset 6: x=40 -> 10+6=16 -> char 2, col 0; row (5>>2)=1.
    pix(40, LY + 5, 1'b1);
    chk("map_char", 32'(char_addr), 2);
    chk("map_col", 32'(glyph_col), 0);
    chk("map_row", 32'(glyph_row), 1);
    chk("map_en", 32'(line_en), 1);
    pix(45, LY + 31, 1'b1);  // 11+6=17 -> char 2, col 1, row 7
    chk("map_last_row_col", 32'(glyph_col), 1);
    chk("map_last_row_row", 32'(glyph_row), 7);
    chk("map_last_row_en", 32'(line_en), 1);
    pix(40, LY + 32, 1'b1);
    chk("map_below_band", 32'(line_en), 0);
    pix(40, LY - 1, 1'b1);
    chk("map_above_band", 32'(line_en), 0);
    pix(40, LY + 5, 1'b0);
    chk("map_de_low", 32'(line_en), 0);
    de = 1'b0;

    // Wrap: 6-8 -> 510; 510+4 -> 2; 2-1 -> 1; 1-3 -> 510.
    speed = 4'd8;
    dir   = 1'b1;
    tick();
    chk("wrap_down_510", 32'(offset), 510);
    speed = 4'd4;
    dir   = 1'b0;
    tick();
    chk("wrap_up_2", 32'(offset), 2);
    speed = 4'd1;
    dir   = 1'b1;
    tick();
    chk("down_1", 32'(offset), 1);
    speed = 4'd3;
    tick();
    chk("wrap_down_510b", 32'(offset), 510);

    // Two pause pulses in one frame give a single toggle into PAUSE.
    pulse_pause();
    @(negedge clk_pix);
    pulse_pause();
    tick();
    chk("pause_state", 32'(state), 2);
    chk("pause_offset", 32'(offset), 510);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("pause_frozen", 32'(offset), 510);
    end
    chk("pause_still", 32'(state), 2);
    // Frozen offset still maps pixels: x=0 -> 510 -> char 63, col 6.
    pix(0, LY, 1'b1);
    chk("pause_map_char", 32'(char_addr), 63);
    chk("pause_map_col", 32'(glyph_col), 6);
    chk("pause_map_en", 32'(line_en), 1);
    de = 1'b0;

    // Resume: no advance on the resume tick, advance on the following one.
    pulse_pause();
    tick();
    chk("resume_state", 32'(state), 1);
    chk("resume_offset", 32'(offset), 510);
    tick();
    chk("resume_adv", 32'(offset), 507);

    // Pause pulse coincident with the tick acts at that tick.
    cmd_pause = 1'b1;
    tick();
    cmd_pause = 1'b0;
    chk("coincident_pause", 32'(state), 2);

    // Pause and stop in the same frame: stop wins.
    pulse_pause();
    pulse_stop();
    tick();
    chk("stop_state", 32'(state), 0);
    chk("stop_offset", 32'(offset), 0);
    pix(40, LY + 5, 1'b1);
    chk("idle_line_en", 32'(line_en), 0);
    de = 1'b0;

    // Pause in IDLE is discarded.
    pulse_pause();
    tick();
    chk("idle_pause_ignored", 32'(state), 0);

    // Back to RUN with a nonzero offset and live pixel outputs.
    speed = 4'd2;
    dir   = 1'b0;
    pulse_start();
    tick();
    tick();
    chk("rerun_offset", 32'(offset), 2);
    pix(40, LY + 5, 1'b1);  // 10+2=12 -> char 1, col 4, row 1
    chk("rerun_char", 32'(char_addr), 1);
    chk("rerun_col", 32'(glyph_col), 4);

    // Mid-frame reset with a pending start.
    pulse_stop();
    pulse_start();
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_state", 32'(state), 0);
    chk("midrst_offset", 32'(offset), 0);
    chk("midrst_char", 32'(char_addr), 0);
    chk("midrst_col", 32'(glyph_col), 0);
    chk("midrst_row", 32'(glyph_row), 0);
    chk("midrst_en", 32'(line_en), 0);
    @(negedge clk_pix);
    tick();
    chk("rst_hold_state", 32'(state), 0);
    chk("rst_hold_char", 32'(char_addr), 0);
    rst_n = 1'b1;
    de    = 1'b0;
    @(negedge clk_pix);
    tick();
    chk("post_rst_no_start", 32'(state), 0);
    chk("post_rst_offset", 32'(offset), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
